// File: rtl/bcd_ascii_sender.sv
// Prints a latched packed-BCD value as ASCII digits over a valid/ready byte stream,
// suppressing leading zeros. Define BCD_ASCII_SENDER_CRLF_EN to end each message with CR LF.
module bcd_ascii_sender #(
  parameter int BCDDIGITS = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BCDDIGITS*4-1:0] bcd_in,
  output logic                   busy,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   done
);

  localparam int IW = (BCDDIGITS > 1) ? $clog2(BCDDIGITS) : 1;

`ifdef BCD_ASCII_SENDER_CRLF_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, SKIP = 3'd1, SEND = 3'd2, DONE = 3'd3, CR = 3'd4, LF = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, SKIP = 3'd1, SEND = 3'd2, DONE = 3'd3
  } state_t;
`endif

  state_t                 state, state_next;
  logic [BCDDIGITS*4-1:0] value, value_next;
  logic [IW-1:0]          index, index_next;
  logic [BCDDIGITS*4-1:0] shifted;
  logic [3:0]             digit;

  // The digit under the index is always the one being examined or printed.
  assign shifted = value >> {index, 2'b00};
  assign digit   = shifted[3:0];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      value <= '0;
      index <= '0;
    end else begin
      state <= state_next;
      value <= value_next;
      index <= index_next;
    end
  end

  always_comb begin
    state_next = state;
    value_next = value;
    index_next = index;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          value_next = bcd_in;
          index_next = IW'(BCDDIGITS - 1);
          state_next = SKIP;
        end
      end
      SKIP: begin
        if (digit == 4'd0 && index != '0) begin
          index_next = index - 1'b1;
        end else begin
          state_next = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = (digit <= 4'd9) ? (8'h30 + {4'h0, digit}) : 8'h3F;
        if (tx_ready) begin
          if (index != '0) begin
            index_next = index - 1'b1;
          end else begin
`ifdef BCD_ASCII_SENDER_CRLF_EN
            state_next = CR;
`else
            state_next = DONE;
`endif
          end
        end
      end
`ifdef BCD_ASCII_SENDER_CRLF_EN
      CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (tx_ready) state_next = LF;
      end
      LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (tx_ready) state_next = DONE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd_ascii_sender.sv
// Randomized and directed bench for bcd_ascii_sender, checked every cycle against a
// message-level model (byte queue plus first-byte latency).
module tb_bcd_ascii_sender;

  localparam int BCDDIGITS = 22;
  localparam int W = BCDDIGITS * 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] bcd_in;
  logic         busy;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         done;

  always #5 clk = ~clk;

  bcd_ascii_sender #(.BCDDIGITS(BCDDIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in), .busy(busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .done(done)
  );

  int checks = 0;
  int failures = 0;

  // Model: idle, or waiting m_wait cycles before offering the bytes in m_q, then one done cycle.
  bit         m_active = 1'b0;
  int         m_wait = 0;
  logic [7:0] m_q[$];

  logic [7:0] log_q[$];
  int first_valid, done_at, last_xfer, stall_obs, stalls_left;
  bit done_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStart(input logic [W-1:0] v);
    int top;
    logic [3:0] d;
    top = BCDDIGITS - 1;
    while (top > 0 && v[top*4 +: 4] == 4'd0) top--;
    m_q.delete();
    for (int i = top; i >= 0; i--) begin
      d = v[i*4 +: 4];
      m_q.push_back((d < 4'd10) ? (8'h30 + {4'h0, d}) : 8'h3F);
    end
`ifdef BCD_ASCII_SENDER_CRLF_EN
    m_q.push_back(8'h0D);
    m_q.push_back(8'h0A);
`endif
    m_wait = 1 + (BCDDIGITS - 1 - top);
    m_active = 1'b1;
  endtask

  task automatic modelStep(input bit s, input logic [W-1:0] b, input bit r);
    if (!m_active) begin
      if (s) modelStart(b);
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (m_q.size() > 0) begin
      if (r) void'(m_q.pop_front());
    end else begin
      m_active = 1'b0;
    end
  endtask

  task automatic checkOutput();
    bit exp_valid, exp_done;
    logic [7:0] exp_data;
    exp_valid = m_active && m_wait == 0 && m_q.size() > 0;
    exp_done  = m_active && m_wait == 0 && m_q.size() == 0;
    exp_data  = exp_valid ? m_q[0] : 8'h00;
    chk("busy", 32'(busy), 32'(m_active));
    chk("tx_valid", 32'(tx_valid), 32'(exp_valid));
    chk("tx_data", 32'(tx_data), 32'(exp_data));
    chk("done", 32'(done), 32'(exp_done));
  endtask

  // Inputs set at a negedge apply to the following posedge; outputs seen there belong to cycle cyc.
  task automatic applyStimulus(input bit s, input logic [W-1:0] b, input bit r_req, input int cyc);
    bit r;
    @(negedge clk);
    checkOutput();
    r = r_req;
    if (stalls_left > 0 && tx_valid && tx_data == 8'h30) begin
      r = 1'b0;
      stalls_left--;
      stall_obs++;
    end
    if (tx_valid && r) begin
      log_q.push_back(tx_data);
      last_xfer = cyc;
    end
    if (tx_valid && first_valid < 0) first_valid = cyc;
    if (done) begin
      done_seen = 1'b1;
      done_at = cyc;
    end
    start = s;
    bcd_in = b;
    tx_ready = r;
    modelStep(s, b, r);
  endtask

  task automatic doReset();
    @(negedge clk);
    checkOutput();
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_data", 32'(tx_data), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    m_active = 1'b0;
    m_wait = 0;
    m_q.delete();
    start = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] junk();
    return W'({$urandom, $urandom, $urandom});
  endfunction

  task automatic runMsg(input logic [W-1:0] v, input int stall_len, input bit repulse, input bit rst_after2);
    bit s;
    log_q.delete();
    first_valid = -1; done_at = -1; last_xfer = -1; done_seen = 1'b0;
    stall_obs = 0; stalls_left = stall_len;
    applyStimulus(1'b1, v, 1'b1, 0);
    for (int i = 1; i < 300; i++) begin
      if (rst_after2 && log_q.size() == 2) begin
        doReset();
        break;
      end
      s = repulse && (i == 5 || i == 21);
      applyStimulus(s, s ? W'(88'h99) : junk(), 1'b1, i);
      if (done_seen) break;
    end
    if (!rst_after2) chk("msg_timeout", 32'(done_seen), 32'd1);
    stalls_left = 0;
  endtask

  task automatic chkBytes(input string name, input logic [7:0] e[$]);
    chk({name, "_len"}, 32'(log_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < log_q.size(); i++)
      chk({name, "_byte"}, 32'(log_q[i]), 32'(e[i]));
  endtask

  task automatic addCrlf(inout logic [7:0] e[$]);
`ifdef BCD_ASCII_SENDER_CRLF_EN
    e.push_back(8'h0D);
    e.push_back(8'h0A);
`endif
  endtask

  task automatic randomMsg();
    logic [W-1:0] v;
    int z, rst_at;
    bit do_rst;
    for (int k = 0; k < BCDDIGITS; k++)
      v[k*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    z = $urandom_range(0, BCDDIGITS);
    for (int k = BCDDIGITS - z; k < BCDDIGITS; k++) v[k*4 +: 4] = 4'd0;
    do_rst = ($urandom_range(0, 9) == 0);
    rst_at = $urandom_range(1, 40);
    applyStimulus(1'b1, v, $urandom_range(0, 1) == 1, 0);
    for (int i = 1; i < 400; i++) begin
      if (do_rst && i == rst_at) begin
        doReset();
        break;
      end
      applyStimulus($urandom_range(0, 5) == 0, junk(), $urandom_range(0, 3) != 0, i);
      if (!m_active) break;
    end
    chk("rand_timeout", 32'(m_active), 32'd0);
    for (int i = 0; i < $urandom_range(0, 3); i++)
      applyStimulus(1'b0, junk(), $urandom_range(0, 1) == 1, 0);
  endtask

  initial begin
    logic [7:0] e[$];
    rst_n = 1'b0; start = 1'b0; bcd_in = '0; tx_ready = 1'b1; stalls_left = 0;
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(tx_valid), 32'd0);
    chk("reset_data", 32'(tx_data), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runMsg(W'(88'h1234), 0, 1'b0, 1'b0);
    chk("fv_1234", 32'(first_valid), 32'd20);
    e = '{8'h31, 8'h32, 8'h33, 8'h34}; addCrlf(e);
    chkBytes("bytes_1234", e);
    chk("done_after_last", 32'(done_at), 32'(last_xfer + 1));

    runMsg('0, 0, 1'b0, 1'b0);
    chk("fv_zero", 32'(first_valid), 32'd23);
    e = '{8'h30}; addCrlf(e);
    chkBytes("bytes_zero", e);

    runMsg(W'(88'h907), 5, 1'b0, 1'b0);
    chk("stall_cycles", 32'(stall_obs), 32'd5);
    chk("fv_907", 32'(first_valid), 32'd21);
    e = '{8'h39, 8'h30, 8'h37}; addCrlf(e);
    chkBytes("bytes_907", e);

    runMsg(W'(88'h1234), 0, 1'b1, 1'b0);
    e = '{8'h31, 8'h32, 8'h33, 8'h34}; addCrlf(e);
    chkBytes("bytes_repulse", e);

    runMsg(W'(88'h1234), 0, 1'b0, 1'b1);
    chk("rst_no_done", 32'(done_seen), 32'd0);
    e = '{8'h31, 8'h32};
    chkBytes("bytes_pre_rst", e);
    runMsg(W'(88'h5), 0, 1'b0, 1'b0);
    e = '{8'h35}; addCrlf(e);
    chkBytes("bytes_after_rst", e);

    runMsg(W'(88'h42), 0, 1'b0, 1'b0);
    e = '{8'h34, 8'h32}; addCrlf(e);
    chkBytes("bytes_42", e);

    for (int n = 0; n < 40; n++) randomMsg();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_ascii_sender.md
BCD_ASCII_SENDER -- requirements
Module: bcd_ascii_sender

Interface
REQ-001 Parameter: BCDDIGITS, 22, number of packed BCD digits on bcd_in (digit 0 = least significant, bits [3:0]).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to print the value on bcd_in.
REQ-005 Port: bcd_in  input  BCDDIGITS*4  packed BCD value from the binary-to-BCD converter.
REQ-006 Port: busy  output  1  high whenever state is not IDLE.
REQ-007 Port: tx_data  output  8  ASCII byte offered to the UART transmitter.
REQ-008 Port: tx_valid  output  1  tx_data is valid.
REQ-009 Port: tx_ready  input  1  transmitter accepts tx_data this cycle.
REQ-010 Port: done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-011 States SHALL be IDLE, SKIP, SEND, CR, LF, DONE.
REQ-012 In IDLE with start=1, the block SHALL latch bcd_in, set digit index to BCDDIGITS-1 and enter SKIP.
REQ-013 start SHALL be ignored in every state other than IDLE; bcd_in changes after the latch SHALL have no effect.
REQ-014 SKIP SHALL examine one digit per cycle: if digit==0 and index>0, decrement index and stay; otherwise enter SEND.
REQ-015 An all-zero value SHALL print exactly one '0' (0x30).
REQ-016 First tx_valid SHALL assert exactly 2+L cycles after the start cycle, where L is the number of leading zero digits skipped (0..BCDDIGITS-1).
REQ-017 In SEND, tx_valid=1 and tx_data=0x30+digit for digits 0-9; digits 10-15 SHALL emit 0x3F ('?').
REQ-018 A byte transfers only on a cycle with tx_valid=1 and tx_ready=1; tx_data and tx_valid SHALL stay stable while tx_ready=0.
REQ-019 On transfer in SEND: if index>0, decrement index and stay in SEND (back-to-back bytes, no idle cycle); if index==0, go to CR.
REQ-020 CR SHALL offer 0x0D, then LF SHALL offer 0x0A, each with the same handshake; LF transfer goes to DONE.
REQ-021 DONE SHALL assert done for exactly one cycle with tx_valid=0, then return to IDLE; busy SHALL drop in that IDLE cycle.
REQ-022 tx_valid SHALL be 0 in IDLE, SKIP and DONE; tx_data SHALL be 0x00 whenever tx_valid=0.
REQ-023 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-024 tx_ready is a don't-care when tx_valid=0 and SHALL NOT change state.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, busy=0, tx_valid=0, tx_data=0x00, done=0, index=0 and clear the latched value.
REQ-026 Reset asserted mid-transmission SHALL abandon the message; no further bytes and no done pulse SHALL follow.
REQ-027 After rst_n rises, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-028 Macro BCD_ASCII_SENDER_CRLF_EN: when defined, the CR and LF states exist and every message ends with 0x0D 0x0A.
REQ-029 Without BCD_ASCII_SENDER_CRLF_EN, the SEND transfer at index 0 SHALL go directly to DONE; no 0x0D/0x0A bytes are ever emitted.

Verification (BCDDIGITS=22, macro defined unless noted, tx_ready=1 unless noted)
REQ-030 bcd_in=0x1234, start pulse at cycle 0 -> tx_valid first at cycle 20, bytes 31 32 33 34 0D 0A on consecutive cycles, done one cycle after 0A.
REQ-031 bcd_in=0, start -> first valid at cycle 23 (21 zero digits skipped), bytes 30 0D 0A, then done.
REQ-032 bcd_in=0x907, tx_ready held low for 5 cycles on byte '0' -> tx_data stays 0x30 and tx_valid stays high for all 5 cycles; full stream 39 30 37 0D 0A.
REQ-033 rst_n pulsed low after byte '2' of 0x1234 -> tx_valid and busy drop asynchronously, no done; new start with 0x5 -> 35 0D 0A.
REQ-034 start re-pulsed with bcd_in=0x99 while 0x1234 is printing -> output remains 31 32 33 34 0D 0A only.
REQ-035 Macro undefined, bcd_in=0x42 -> bytes 34 32 then done; no 0D/0A observed.
